// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned REGBITS_DEF = 3;
    localparam int unsigned NREQ_DEF    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Low bit of slot idx in a packed bus of w-bit fields.
    function automatic int unsigned slice_lo(int unsigned idx, int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit searching from ptr upward, wrapping.
module rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = IW + 1;
    localparam logic [SW-1:0] N_V = SW'(N);

    logic [SW-1:0] pos;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + SW'(k);
            if (pos >= N_V) begin
                pos = pos - N_V;
            end
            if (!valid && req[IW'(pos)]) begin
                valid          = 1'b1;
                idx            = IW'(pos);
                gnt[IW'(pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port with a built-in
// clear sequencer that zeroes registers 1..last while holding off requesters.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned REGBITS = REGBITS_DEF,
    parameter int unsigned NREQ    = NREQ_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*REGBITS-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      clr_start,
    output logic                      busy,
    output logic                      regwrite,
    output logic [REGBITS-1:0]        wa,
    output logic [WIDTH-1:0]          wd
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam logic [REGBITS-1:0] LAST_REG = {REGBITS{1'b1}};
    localparam logic [IW-1:0]      LAST_REQ = IW'(NREQ - 1);

    state_t               state_q, state_d;
    logic [REGBITS-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 busy_d, regwrite_d;
    logic [REGBITS-1:0]   wa_d;
    logic [WIDTH-1:0]     wd_d;

    logic [NREQ-1:0]      pick_gnt;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 grant_ok;

    logic [REGBITS-1:0]   addr_a [NREQ];
    logic [WIDTH-1:0]     data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[slice_lo(i, REGBITS) +: REGBITS];
        assign data_a[i] = req_data[slice_lo(i, WIDTH) +: WIDTH];
    end

    rr_picker #(.N(NREQ)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, counter, pointer and write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            busy     <= 1'b0;
            regwrite <= 1'b0;
            wa       <= '0;
            wd       <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            busy     <= busy_d;
            regwrite <= regwrite_d;
            wa       <= wa_d;
            wd       <= wd_d;
        end
    end

    // Next state: clr_start launches the sweep, which stops after the last register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = REGBITS'(1);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_REG) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + REGBITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant and next write-port values; the clear sweep overrides requesters.
    always_comb begin
        grant_ok   = rst_n && (state_q == ST_IDLE) && !clr_start;
        ack        = grant_ok ? pick_gnt : '0;
        busy_d     = (state_d == ST_CLEAR);
        regwrite_d = 1'b0;
        wa_d       = wa;
        wd_d       = wd;
        ptr_d      = ptr_q;
        if (state_d == ST_CLEAR) begin
            regwrite_d = 1'b1;
            wa_d       = cnt_d;
            wd_d       = '0;
        end else if (grant_ok && pick_valid) begin
            regwrite_d = (addr_a[pick_idx] != '0);
            wa_d       = addr_a[pick_idx];
            wd_d       = data_a[pick_idx];
            ptr_d      = (pick_idx == LAST_REQ) ? '0 : pick_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a cycle-level reference model.
module tb_regfile_wr_arbiter;

    localparam int N = 4;
    localparam int M = 7;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        clr_start;
    logic        busy;
    logic        regwrite;
    logic [2:0]  wa;
    logic [7:0]  wd;

    int n_checks = 0;
    int n_err    = 0;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .clr_start (clr_start),
        .busy      (busy),
        .regwrite  (regwrite),
        .wa        (wa),
        .wd        (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int         m_ptr   = 0;
    bit         m_clear = 0;
    int         m_k     = 0;
    bit         m_rw    = 0;
    logic [2:0] m_wa    = '0;
    logic [7:0] m_wd    = '0;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ack();
        int g;
        if (!rst_n || m_clear || clr_start) return 4'b0000;
        g = pick();
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_clear = 0; m_k = 0; m_rw = 0; m_wa = '0; m_wd = '0;
        end else if (m_clear) begin
            if (m_k == M) begin
                m_clear = 0;
                m_rw    = 0;
            end else begin
                m_k  = m_k + 1;
                m_wa = 3'(m_k);
                m_wd = '0;
            end
        end else if (clr_start) begin
            m_clear = 1; m_k = 1; m_rw = 1; m_wa = 3'd1; m_wd = '0;
        end else begin
            int g;
            g = pick();
            if (g >= 0) begin
                m_wa  = req_addr[g*3 +: 3];
                m_wd  = req_data[g*8 +: 8];
                m_rw  = (m_wa != 0);
                m_ptr = (g + 1) % N;
            end else begin
                m_rw = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("model_ack",      32'(ack),      32'(exp_ack()));
        check("model_busy",     32'(busy),     32'(m_clear));
        check("model_regwrite", 32'(regwrite), 32'(m_rw));
        check("model_wa",       32'(wa),       32'(m_wa));
        check("model_wd",       32'(wd),       32'(m_wd));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int a, input int d);
        req_addr[i*3 +: 3] = 3'(a);
        req_data[i*8 +: 8] = 8'(d);
    endtask

    logic [3:0] seq  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [2:0] seqa [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd5};

    initial begin
        rst_n     = 1'b0;
        clr_start = 1'b0;
        req       = 4'($urandom);
        req_addr  = 12'($urandom);
        req_data  = $urandom;
        repeat (3) step();
        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_regwrite", 32'(regwrite), 0);
        check("rst_wa", 32'(wa), 0);
        check("rst_wd", 32'(wd), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        req   = '0;
        rst_n = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("post_rst_regwrite", 32'(regwrite), 0);
        check("post_rst_ack", 32'(ack), 0);

        // Single request from requester 2
        req_addr = '0;
        req_data = '0;
        set_slot(2, 3, 8'h18);
        req = 4'b0100;
        @(negedge clk);
        check("single_ack", 32'(ack), 32'b0100);
        step();
        req = '0;
        @(negedge clk);
        check("single_regwrite", 32'(regwrite), 1);
        check("single_wa", 32'(wa), 3);
        check("single_wd", 32'(wd), 8'h18);
        step();
        set_slot(3, 6, 8'h33);
        req = 4'b1000;
        @(negedge clk);
        check("ptr3_ack", 32'(ack), 32'b1000);
        step();

        // Fairness from ptr=0
        for (int i = 0; i < N; i++) set_slot(i, i + 4, 8'h10 * (i + 1));
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("fair_ack", 32'(ack), 32'(seq[k]));
            if (k > 0) check("fair_wa", 32'(wa), 32'(seqa[k-1]));
            step();
        end
        req = '0;
        @(negedge clk);
        check("fair_last_wa", 32'(wa), 5);
        check("fair_last_wd", 32'(wd), 8'h20);
        step();

        // Write to register 0 is acked but not written
        set_slot(1, 0, 8'hFF);
        req = 4'b0010;
        @(negedge clk);
        check("zero_ack", 32'(ack), 32'b0010);
        step();
        req = 4'b0110;
        @(negedge clk);
        check("zero_regwrite", 32'(regwrite), 0);
        check("zero_wa", 32'(wa), 0);
        check("zero_wd", 32'(wd), 8'hFF);
        check("zero_next_ack", 32'(ack), 32'b0100);
        step();
        req = '0;
        @(negedge clk);
        check("zero_next_wa", 32'(wa), 6);
        check("zero_next_wd", 32'(wd), 8'h30);
        step();

        // Clear sequence with a waiting requester
        set_slot(1, 5, 8'h5A);
        req       = 4'b0010;
        clr_start = 1'b1;
        @(negedge clk);
        check("clr_start_ack", 32'(ack), 0);
        step();
        clr_start = 1'b0;
        for (int k = 1; k <= M; k++) begin
            @(negedge clk);
            check("clr_busy", 32'(busy), 1);
            check("clr_regwrite", 32'(regwrite), 1);
            check("clr_wa", 32'(wa), 32'(k));
            check("clr_wd", 32'(wd), 0);
            check("clr_ack", 32'(ack), 0);
            step();
        end
        @(negedge clk);
        check("clr_end_busy", 32'(busy), 0);
        check("clr_end_regwrite", 32'(regwrite), 0);
        check("clr_end_ack", 32'(ack), 32'b0010);
        step();
        req = '0;
        @(negedge clk);
        check("after_clr_regwrite", 32'(regwrite), 1);
        check("after_clr_wa", 32'(wa), 5);
        check("after_clr_wd", 32'(wd), 8'h5A);
        step();

        // Reset in the middle of a clear
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_regwrite", 32'(regwrite), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_wa", 32'(wa), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("midrst_after_busy", 32'(busy), 0);
        check("midrst_after_regwrite", 32'(regwrite), 0);
        check("midrst_after_wa", 32'(wa), 0);
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        @(negedge clk);
        check("restart_busy", 32'(busy), 1);
        check("restart_wa", 32'(wa), 1);
        check("restart_regwrite", 32'(regwrite), 1);
        repeat (8) step();
        @(negedge clk);
        check("restart_done_busy", 32'(busy), 0);
        check("restart_done_regwrite", 32'(regwrite), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
